// File: rtl/mips_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : mips_muldiv
// Description : Iterative 32-bit multiply/divide unit placed beside the
//               MIPS_32 ALU. Handles MULT/MULTU/DIV/DIVU with a
//               start/busy/done handshake and owns the HI/LO registers.
//               Multiply is shift-add (LSB first); divide is restoring.
//               One bit per cycle, 32 iterations.
// Ports       : clk            rising-edge clock
//               reset          asynchronous active-low reset
//               S, T [31:0]    rs / rt operands
//               FS   [4:0]     function select (1A..1D)
//               start          request, sampled only in IDLE
//               busy           operation in flight
//               done           one-cycle pulse when HI/LO/flags update
//               Y_hi, Y_lo     HI / LO registers
//               C, V, N, Z     carry (always 0), overflow, negative, zero
// Revision    : 1.0 - initial release
// ============================================================================
module mips_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] S,
    input  logic [31:0] T,
    input  logic [4:0]  FS,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] Y_hi,
    output logic [31:0] Y_lo,
    output logic        C,
    output logic        V,
    output logic        N,
    output logic        Z
);

    localparam logic [4:0] c_FS_MULT  = 5'h1A;
    localparam logic [4:0] c_FS_MULTU = 5'h1B;
    localparam logic [4:0] c_FS_DIV   = 5'h1C;
    localparam logic [4:0] c_FS_DIVU  = 5'h1D;
    localparam logic [5:0] c_LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Latched operation context
    logic        r_is_div;
    logic        r_neg_s;
    logic        r_neg_t;
    logic        r_dbz;
    logic        r_ovf;
    logic [5:0]  r_cnt;
    logic [31:0] r_opnd;     // multiplicand magnitude or divisor magnitude
    logic [63:0] r_acc;      // product accumulator or {rem, quot}

    // Output registers
    logic [31:0] r_y_hi;
    logic [31:0] r_y_lo;
    logic        r_done;
    logic        r_n;
    logic        r_z;
    logic        r_v;

    // FSM decode strobes
    logic        w_accept;
    logic        w_iter;
    logic        w_fix;

    // ------------------------------------------------------------------
    // Input decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic        w_fs_valid;
    logic        w_in_signed;
    logic        w_in_div;
    logic        w_in_dbz;
    logic        w_in_ovf;
    logic [31:0] w_s_mag;
    logic [31:0] w_t_mag;

    always_comb begin
        w_fs_valid  = (FS == c_FS_MULT) || (FS == c_FS_MULTU) ||
                      (FS == c_FS_DIV)  || (FS == c_FS_DIVU);
        w_in_signed = (FS == c_FS_MULT) || (FS == c_FS_DIV);
        w_in_div    = (FS == c_FS_DIV)  || (FS == c_FS_DIVU);
        w_in_dbz    = w_in_div && (T == 32'd0);
        // The only signed quotient that does not fit in 32 bits
        w_in_ovf    = (FS == c_FS_DIV) && (S == 32'h8000_0000) &&
                      (T == 32'hFFFF_FFFF);
        w_s_mag     = (w_in_signed && S[31]) ? (~S + 32'd1) : S;
        w_t_mag     = (w_in_signed && T[31]) ? (~T + 32'd1) : T;
    end

    // ------------------------------------------------------------------
    // One iteration step for each operation
    // ------------------------------------------------------------------
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_acc;
    logic [32:0] w_div_trial;
    logic [63:0] w_div_acc;

    always_comb begin
        // Multiplier bits sit in the low word and shift out as the
        // product fills in from the top.
        w_mul_sum = {1'b0, r_acc[63:32]};
        if (r_acc[0]) begin
            w_mul_sum = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
        end
        w_mul_acc = {w_mul_sum, r_acc[31:1]};

        // Trial subtraction on the upper 33 bits after the left shift;
        // bit 32 of the difference is the borrow.
        w_div_trial = r_acc[63:31] - {1'b0, r_opnd};
        if (w_div_trial[32]) begin
            w_div_acc = {r_acc[62:0], 1'b0};
        end else begin
            w_div_acc = {w_div_trial[31:0], r_acc[30:0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up and flag generation for the FIX state
    // ------------------------------------------------------------------
    logic        w_sgn_diff;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_n;
    logic        w_res_z;
    logic        w_res_v;

    always_comb begin
        // Sign flags are only ever set for the signed codes, so the
        // unsigned codes fall through without negation.
        w_sgn_diff = r_neg_s ^ r_neg_t;
        w_prod     = w_sgn_diff ? (~r_acc + 64'd1) : r_acc;
        w_quot     = w_sgn_diff ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
        w_rem      = r_neg_s ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        w_res_v  = 1'b0;
        if (r_is_div) begin
            if (r_dbz) begin
                // Accumulator was preloaded with {S, all-ones}
                w_res_hi = r_acc[63:32];
                w_res_lo = r_acc[31:0];
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
            w_res_v = r_dbz || r_ovf;
            w_res_n = w_res_lo[31];
            w_res_z = (w_res_lo == 32'd0);
        end else begin
            w_res_n = w_res_hi[31];
            w_res_z = ({w_res_hi, w_res_lo} == 64'd0);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_iter      = 1'b0;
        w_fix       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && w_fs_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_in_dbz ? ST_FIX : ST_CALC;
                end
            end
            ST_CALC: begin
                w_iter = 1'b1;
                if (r_cnt == c_LAST_ITER) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                w_fix       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_div <= 1'b0;
            r_neg_s  <= 1'b0;
            r_neg_t  <= 1'b0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= 6'd0;
            r_opnd   <= 32'd0;
            r_acc    <= 64'd0;
            r_y_hi   <= 32'd0;
            r_y_lo   <= 32'd0;
            r_done   <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_accept) begin
                r_is_div <= w_in_div;
                r_neg_s  <= w_in_signed && S[31];
                r_neg_t  <= w_in_signed && T[31];
                r_dbz    <= w_in_dbz;
                r_ovf    <= w_in_ovf;
                r_cnt    <= 6'd0;
                if (w_in_dbz) begin
                    r_opnd <= 32'd0;
                    r_acc  <= {S, 32'hFFFF_FFFF};
                end else if (w_in_div) begin
                    r_opnd <= w_t_mag;
                    r_acc  <= {32'd0, w_s_mag};
                end else begin
                    r_opnd <= w_s_mag;
                    r_acc  <= {32'd0, w_t_mag};
                end
            end else if (w_iter) begin
                r_cnt <= r_cnt + 6'd1;
                r_acc <= r_is_div ? w_div_acc : w_mul_acc;
            end
            if (w_fix) begin
                r_y_hi <= w_res_hi;
                r_y_lo <= w_res_lo;
                r_n    <= w_res_n;
                r_z    <= w_res_z;
                r_v    <= w_res_v;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign Y_hi = r_y_hi;
    assign Y_lo = r_y_lo;
    assign C    = 1'b0;
    assign V    = r_v;
    assign N    = r_n;
    assign Z    = r_z;

endmodule
`default_nettype wire

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative 32-bit multiply/divide unit that sits beside the MIPS_32 ALU in the execute stage. It consumes the same S/T operands and FS function code. For the MULT/MULTU/DIV/DIVU codes, which the ALU does not implement, it produces the HI/LO pair on Y_hi/Y_lo with N/Z/V/C flags. It is a multi-cycle block with a start/busy/done handshake; the HI/LO registers live here and hold their value between operations.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- S  input  32  rs operand (multiplicand / dividend)
- T  input  32  rt operand (multiplier / divisor)
- FS  input  5  function select: 5'h1A MULT, 5'h1B MULTU, 5'h1C DIV, 5'h1D DIVU
- start  input  1  request; sampled only in IDLE
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when Y_hi/Y_lo/flags update
- Y_hi  output  32  HI register (product upper word / remainder)
- Y_lo  output  32  LO register (product lower word / quotient)
- C  output  1  always 0
- V  output  1  divide exception flag
- N  output  1  negative flag
- Z  output  1  zero flag

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 with a valid FS: latch S, T, FS, and the operand signs. For signed codes, convert operands to magnitudes (two's-complement negate if bit 31 is set). Clear the 6-bit counter and go to CALC.
  - start with any other FS: ignored; no state change, no done.
- Divide by zero (DIV/DIVU with T==0), detected in IDLE: skip CALC and go to FIX. Result: Y_hi=S, Y_lo=32'hFFFFFFFF, V=1.
- CALC, multiply: shift-add over a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division over a 64-bit {rem,quot} register.
  - Each cycle: shift left 1, trial-subtract the divisor from the upper 33 bits.
  - If the trial result is non-negative: keep it and set quotient bit 1; otherwise restore and set quotient bit 0.
- CALC exits to FIX after the 32nd iteration (counter==31).
- FIX: apply sign fix-up, write Y_hi/Y_lo/flags, pulse done, return to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- Flags, updated only in FIX and held otherwise:
  - Multiply: N=Y_hi[31]; Z=({Y_hi,Y_lo}==0); V=0.
  - Divide: N=Y_lo[31]; Z=(Y_lo==0).
  - V=1 for divide by zero and for DIV 32'h80000000 / 32'hFFFFFFFF. That case returns Y_lo=32'h80000000, Y_hi=0.
  - C=0 always.
- Inputs S/T/FS may change freely after the start cycle; only the latched copies are used.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE. busy=0, done=0, Y_hi=0, Y_lo=0, C=0, V=0, N=0, Z=0. Internal counter and accumulators cleared.
- Let E0 be the rising edge that samples start=1 in IDLE.
  - busy=1 from E0.
  - Iterations occur at E1..E32.
  - At E33: Y_hi/Y_lo/flags update, busy=0, done=1.
  - At E34: done=0.
- Divide by zero: FIX at E1, so busy is high for one cycle and done pulses after E1.
- start while busy=1 is ignored (not queued).
- start asserted in the cycle where done=1 is accepted (state is IDLE), so back-to-back operations are possible. done and busy are never both 1.
- Reset asserted mid-operation aborts immediately: outputs return to reset values, and no done is issued for the aborted operation.
- Y_hi/Y_lo change only at FIX or at reset.

## Test plan
- MULT S=32'hFFFFFFFE, T=3 -> done after E33; Y_hi=32'hFFFFFFFF, Y_lo=32'hFFFFFFFA, N=1, Z=0, V=0.
- MULTU S=T=32'hFFFFFFFF -> Y_hi=32'hFFFFFFFE, Y_lo=32'h00000001. MULT with S=0 -> Z=1.
- DIV S=-7 (32'hFFFFFFF9), T=2 -> Y_lo=32'hFFFFFFFD, Y_hi=32'hFFFFFFFF. DIVU S=100, T=7 -> Y_lo=14, Y_hi=2, N=0.
- DIVU S=5, T=0 -> done after E1, Y_hi=5, Y_lo=32'hFFFFFFFF, V=1. DIV 32'h80000000 / 32'hFFFFFFFF -> Y_lo=32'h80000000, Y_hi=0, V=1.
- Pulse start with FS=5'h1C at E5 of a running MULT -> ignored; MULT result unchanged. Start with FS=5'h02 in IDLE -> busy stays 0.
- Assert reset at E10 of a DIV -> busy=0, all outputs 0 immediately, no done. After release, a new MULTU 6*7 -> Y_lo=42 after E33.
